uart_rx_phase_acc: RTL and testbench
====================================

Name: uart_rx_phase_acc

Overview:
- UART receiver: the receive-side counterpart of the phase-accumulator baud generator.
- Holds its own phase accumulator, which is re-phased on every start-bit edge so that sample ticks fall mid-bit (180° offset).
- Deserialises LSB-first 8N1-style frames, with optional parity.
- Presents each byte on a valid/ready hold register to the fabric.

Parameters:
- SYS_CLK_FREQ, 125000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- ACC_WIDTH, 32, phase accumulator width.
- DATA_BITS, 8, data bits per frame (5–9).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data and the error flags are valid.
- rx_ready  in  1  consumer accepts the byte; transfer occurs when rx_valid&&rx_ready.
- frame_err  out  1  stop bit sampled low; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY_EN=0.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Internal: synchroniser flops=1, accumulator=0, state=IDLE.
- Synchroniser: two flops, then one edge-history flop. Start edge = previous synced value 1 and current synced value 0.
- PHASE_INC = floor(BAUD_RATE*2^ACC_WIDTH/SYS_CLK_FREQ), computed in 64-bit.
- Accumulator rules:
  - Adds PHASE_INC every cycle while not IDLE.
  - sample_tick = carry-out of the ACC_WIDTH-bit add.
  - On the start edge in IDLE, load the accumulator with 2^(ACC_WIDTH-1). The first tick then lands half a bit after the edge.
- FSM: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: start edge -> START, with accumulator loaded as above.
  - START tick: synced rx=1 -> IDLE (glitch, no flags). rx=0 -> DATA, bit counter=0.
  - DATA tick: shift rx into bit [DATA_BITS-1], shift right, increment counter. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY tick: parity_err_next = (XOR of data ^ rx) != PARITY_ODD. Then -> STOP.
  - STOP tick, rx=1: commit frame -> IDLE.
  - STOP tick, rx=0: commit frame with frame_err=1 -> WAIT_IDLE.
  - WAIT_IDLE: synced rx=1 -> IDLE. No new start is accepted while the line is held low.
- Commit:
  - Occurs the cycle after the STOP tick.
  - If rx_valid=0, or rx_valid&&rx_ready in the commit cycle: load rx_data and the error flags, and set rx_valid=1.
  - Otherwise, old data is kept, the new frame is discarded, and overrun pulses for 1 cycle.
- rx_valid clears on rx_valid&&rx_ready unless a commit happens in the same cycle. A simultaneous accept and commit yields the new byte with rx_valid held at 1.
- rx_data and the flags stay stable while rx_valid=1 and rx_ready=0.
- Asynchronous reset mid-frame aborts the frame. No output is produced for that frame.
- Accumulator wrap is modular. The fractional error must accumulate by less than 0.5 bit over the frame; this is the user's responsibility for the chosen parameters.

Decomposition:
- Shared package uart_pkg:
  - State enum rx_state_t.
  - Function phase_inc(sys_clk, baud, width) returning longint, also usable by the baud generator.
- Sub-module rx_sync_edge: 2-flop synchroniser plus falling-edge detect, reset to 1.
- Everything else in one module.

Test Plan:
Bench parameters: SYS_CLK_FREQ=1000000, BAUD_RATE=62500 (16 clk/bit, PHASE_INC=0x10000000).
1. Send 0xA5 8N1, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, frame_err=0, parity_err=0. Ticks fall 8 clk after the detected edge, then every 16 clk.
2. Low glitch of 4 clk on an idle line -> FSM returns to IDLE at the START tick; rx_valid never asserts; busy drops.
3. Send 0x3C with the stop bit driven 0, then line high -> rx_data=0x3C, frame_err=1. FSM waits in WAIT_IDLE until rx=1; a following 0x55 frame is received cleanly.
4. PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong) -> parity_err=1, rx_data=0x07. Repeat with parity bit 1 -> parity_err=0.
5. Hold rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses 1 cycle at the second commit. Raising rx_ready then clears rx_valid.
6. Assert reset low during DATA bit 3 of a frame, release, send 0x81 -> outputs at reset values; no partial byte; 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the phase-increment helper
// used by both the baud generator and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // floor(baud * 2^width / sys_clk), evaluated in 64-bit so 32-bit accumulators do not overflow.
    function automatic longint phase_inc(input longint sys_clk, input longint baud, input int width);
        return (baud << width) / sys_clk;
    endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the async rx line plus a history flop for falling-edge detect.
// Latency: 2 clk to rx_sync; start_edge asserts the first cycle rx_sync is low after being high.
module rx_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic start_edge
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // All stages reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rx_sync    = sync_q;
    assign start_edge = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx_phase_acc.sv
// UART receiver with a phase accumulator re-phased on each start edge so ticks land mid-bit.
// Byte committed the cycle after the stop tick into a valid/ready hold register; a full register drops the frame and pulses overrun.
module uart_rx_phase_acc
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 125000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned DATA_BITS    = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam longint INC_L = phase_inc(longint'(SYS_CLK_FREQ), longint'(BAUD_RATE), int'(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] PHASE_INC  = INC_L[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] HALF_PHASE = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]     LAST_BIT   = CNT_W'(DATA_BITS - 1);

    logic rx_s;
    logic start_edge;

    rx_state_t state_q;
    rx_state_t state_d;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 tick;

    logic [DATA_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 par_err_q;
    logic                 commit_q;
    logic                 commit_ferr_q;

    logic start_ok;
    logic shift_en;
    logic par_chk;
    logic stop_tick;
    logic accept;

    rx_sync_edge u_sync (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_sync    (rx_s),
        .start_edge (start_edge)
    );

    // Carry-out of the accumulator add is the sample tick; no ticks while idle.
    assign acc_sum = {1'b0, acc_q} + {1'b0, PHASE_INC};
    assign tick    = (state_q != IDLE) && acc_sum[ACC_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    par_chk = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_tick = 1'b1;
                    state_d   = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A line held low after a framing error must not be taken as a new start.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            par_err_q     <= 1'b0;
            commit_q      <= 1'b0;
            commit_ferr_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (start_edge) begin
                    acc_q <= HALF_PHASE;
                end
            end else begin
                acc_q <= acc_sum[ACC_WIDTH-1:0];
            end

            if (start_ok) begin
                bit_cnt_q <= '0;
                par_err_q <= 1'b0;
            end

            if (shift_en) begin
                shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (par_chk) begin
                par_err_q <= (((^shreg_q) ^ rx_s) != PARITY_ODD);
            end

            commit_q      <= stop_tick;
            commit_ferr_q <= stop_tick & ~rx_s;
        end
    end

    // Room in the hold register if it is empty or being drained this very cycle.
    assign accept = ~rx_valid | rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_q) begin
                if (accept) begin
                    rx_data    <= shreg_q;
                    frame_err  <= commit_ferr_q;
                    parity_err <= PARITY_EN & par_err_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_phase_acc.sv
// Directed bench: 16 clk/bit, one 8N1 receiver and one even-parity receiver on separate lines.
module tb_uart_rx_phase_acc;

    localparam int BIT_CLK = 16;

    logic       clk;
    logic       reset;
    logic       rx_a, rx_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       rx_ready_a, rx_ready_b;
    logic       frame_err_a, frame_err_b;
    logic       parity_err_a, parity_err_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int ovr_a = 0;
    int ovr_b = 0;
    int busy_cyc_a = 0;

    uart_rx_phase_acc #(
        .SYS_CLK_FREQ (1000000),
        .BAUD_RATE    (62500),
        .ACC_WIDTH    (32),
        .DATA_BITS    (8),
        .PARITY_EN    (1'b0),
        .PARITY_ODD   (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_a),
        .rx_data    (rx_data_a),
        .rx_valid   (rx_valid_a),
        .rx_ready   (rx_ready_a),
        .frame_err  (frame_err_a),
        .parity_err (parity_err_a),
        .overrun    (overrun_a),
        .busy       (busy_a)
    );

    uart_rx_phase_acc #(
        .SYS_CLK_FREQ (1000000),
        .BAUD_RATE    (62500),
        .ACC_WIDTH    (32),
        .DATA_BITS    (8),
        .PARITY_EN    (1'b1),
        .PARITY_ODD   (1'b0)
    ) dut_p (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_b),
        .rx_data    (rx_data_b),
        .rx_valid   (rx_valid_b),
        .rx_ready   (rx_ready_b),
        .frame_err  (frame_err_b),
        .parity_err (parity_err_b),
        .overrun    (overrun_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_a && rx_ready_a) q_a.push_back({parity_err_a, frame_err_a, rx_data_a});
        if (rx_valid_b && rx_ready_b) q_b.push_back({parity_err_b, frame_err_b, rx_data_b});
        if (overrun_a) ovr_a++;
        if (overrun_b) ovr_b++;
        if (busy_a) busy_cyc_a++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic stop,
                              input logic use_par, input logic par, input int tail_hi);
        logic [7:0] bits;
        bits = d;
        drive(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(sel, bits[i], BIT_CLK);
        if (use_par) drive(sel, par, BIT_CLK);
        drive(sel, stop, BIT_CLK);
        if (tail_hi > 0) drive(sel, 1'b1, tail_hi);
    endtask

    task automatic check_frame(input string nm, input logic sel, input logic [7:0] ed,
                               input logic ef, input logic ep);
        int waited;
        int sz;
        logic [9:0] ent;
        waited = 0;
        sz = sel ? q_b.size() : q_a.size();
        while (sz == 0 && waited < 400) begin
            @(posedge clk);
            waited++;
            sz = sel ? q_b.size() : q_a.size();
        end
        #1;
        if (sz == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_present: got no byte within 400 cycles, required 1 byte", nm);
        end else begin
            check({nm, "_count"}, 32'(sz), 32'd1);
            if (sel) ent = q_b.pop_front(); else ent = q_a.pop_front();
            check({nm, "_data"}, 32'(ent[7:0]), 32'(ed));
            check({nm, "_ferr"}, 32'(ent[8]), 32'(ef));
            check({nm, "_perr"}, 32'(ent[9]), 32'(ep));
            if (sel) q_b.delete(); else q_a.delete();
        end
    endtask

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       stop;
        logic       use_par;
        logic       par;
        logic [7:0] e_data;
        logic       e_ferr;
        logic       e_perr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int base_ovr;
        int base_busy;

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};

        reset      = 1'b0;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b1;
        rx_ready_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid_a", 32'(rx_valid_a), 32'd0);
        check("rst_data_a", 32'(rx_data_a), 32'd0);
        check("rst_ferr_a", 32'(frame_err_a), 32'd0);
        check("rst_perr_a", 32'(parity_err_a), 32'd0);
        check("rst_ovr_a", 32'(overrun_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_valid_b", 32'(rx_valid_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b1, 8);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].stop, vecs[i].use_par, vecs[i].par, BIT_CLK);
            check_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e_data, vecs[i].e_ferr, vecs[i].e_perr);
        end

        // Short low glitch: busy for exactly the half bit up to the START tick.
        base_busy = busy_cyc_a;
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 40);
        check("glitch_busy_cycles", 32'(busy_cyc_a - base_busy), 32'd8);
        check("glitch_no_byte", 32'(q_a.size()), 32'd0);
        check("glitch_busy_low", 32'(busy_a), 32'd0);

        // Framing error with line held low, then a clean frame.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 48);
        check("wait_idle_busy", 32'(busy_a), 32'd1);
        check("wait_idle_one_byte", 32'(q_a.size()), 32'd1);
        drive(1'b0, 1'b1, 20);
        check("wait_idle_exit", 32'(busy_a), 32'd0);
        check_frame("ferr_hold", 1'b0, 8'h3C, 1'b1, 1'b0);
        send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, BIT_CLK);
        check_frame("after_ferr", 1'b0, 8'h55, 1'b0, 1'b0);

        // Overrun: hold register full while a second frame completes.
        rx_ready_a = 1'b0;
        base_ovr = ovr_a;
        send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, BIT_CLK);
        check("hold_valid", 32'(rx_valid_a), 32'd1);
        check("hold_data", 32'(rx_data_a), 32'h11);
        send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, BIT_CLK);
        check("ovr_pulses", 32'(ovr_a - base_ovr), 32'd1);
        check("ovr_data_kept", 32'(rx_data_a), 32'h11);
        check("ovr_valid_kept", 32'(rx_valid_a), 32'd1);
        rx_ready_a = 1'b1;
        drive(1'b0, 1'b1, 3);
        check("ovr_valid_cleared", 32'(rx_valid_a), 32'd0);
        check_frame("ovr_accept", 1'b0, 8'h11, 1'b0, 1'b0);

        // Reset asserted partway through data bit 3.
        drive(1'b0, 1'b0, BIT_CLK);
        drive(1'b0, 1'b1, BIT_CLK);
        drive(1'b0, 1'b0, BIT_CLK);
        drive(1'b0, 1'b0, BIT_CLK);
        drive(1'b0, 1'b0, 8);
        check("midframe_busy", 32'(busy_a), 32'd1);
        reset = 1'b0;
        drive(1'b0, 1'b1, 4);
        check("mrst_valid", 32'(rx_valid_a), 32'd0);
        check("mrst_data", 32'(rx_data_a), 32'd0);
        check("mrst_ferr", 32'(frame_err_a), 32'd0);
        check("mrst_perr", 32'(parity_err_a), 32'd0);
        check("mrst_busy", 32'(busy_a), 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b1, 20);
        check("mrst_no_partial", 32'(q_a.size()), 32'd0);
        send_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b0, BIT_CLK);
        check_frame("after_rst", 1'b0, 8'h81, 1'b0, 1'b0);

        check("par_dut_no_overrun", 32'(ovr_b), 32'd0);
        check("par_dut_idle", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
